// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the instruction-fetch stage.
package pipe_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic {FETCH, HALT} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } if_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem request/response, redirect and IF/ID handshake signals.
interface fetch_stage_if;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_inst;
  logic        redirect_valid, id_stall, if_valid, if_adel;
  logic [31:0] redirect_pc, if_pc, if_inst;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_adel,
    input  imem_req_ready, imem_resp_valid, imem_resp_inst, redirect_valid, redirect_pc, id_stall
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_adel,
    output imem_req_ready, imem_resp_valid, imem_resp_inst, redirect_valid, redirect_pc, id_stall
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: sync FIFO with push, pop and single-cycle flush; a push in the flush cycle lands in the emptied FIFO.
module fetch_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, wa;
  logic [AW:0] cnt_q, cnt_d;
  logic do_pop;
  always_comb begin
    do_pop = pop && !flush && cnt_q != '0;
    wa = flush ? '0 : wr_q;
    mem_d = mem_q;
    if (push) mem_d[wa] = din;
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    wr_d = wa + AW'(push);
    cnt_d = (flush ? '0 : cnt_q - (AW+1)'(do_pop)) + (AW+1)'(push);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues credit-limited in-order imem requests and
// buffers returned instructions for ID; redirects flush and discard wrong-path fetches.
module fetch_stage import pipe_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int BUF_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  fetch_stage_if.master bus
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, pcq_head;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, buf_cnt, pcq_cnt;
  logic run_q, hs, live, aligned, redirect, pop;
  logic buf_push, buf_full, buf_empty, pcq_full, pcq_empty;
  if_entry_t buf_din, buf_dout, head;
  // run_q keeps requests off during and right after reset
  assign bus.imem_req_valid = run_q && state_q == FETCH &&
                              ({1'b0, out_q} + {1'b0, buf_cnt}) < (CW+1)'(BUF_DEPTH);
  assign bus.imem_req_addr = pc_q;
  assign redirect = bus.redirect_valid;
  assign aligned = bus.redirect_pc[1:0] == 2'b00;
  assign hs = bus.imem_req_valid && bus.imem_req_ready;
  assign live = bus.imem_resp_valid && disc_q == '0;
  assign pop = bus.if_valid && !bus.id_stall;
  always_comb begin
    out_d = out_q + CW'(hs) - CW'(bus.imem_resp_valid);
    disc_d = redirect ? out_d : disc_q - CW'(bus.imem_resp_valid && disc_q != '0);
    pc_d = redirect ? (aligned ? bus.redirect_pc : pc_q) : pc_q + (hs ? 32'd4 : 32'd0);
    state_d = redirect ? (aligned ? FETCH : HALT) : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      out_q <= '0;
      disc_q <= '0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
      run_q <= 1'b1;
    end
  end
  assign buf_push = redirect ? !aligned : live;
  assign buf_din = redirect ? if_entry_t'{pc: bus.redirect_pc, inst: NOP, adel: 1'b1}
                            : if_entry_t'{pc: pcq_head, inst: bus.imem_resp_inst, adel: 1'b0};
  fetch_buffer #(.WIDTH($bits(if_entry_t)), .DEPTH(BUF_DEPTH)) u_ibuf (
    .clk(clk), .rst_n(rst_n), .push(buf_push), .pop(pop), .flush(redirect),
    .din(buf_din), .dout(buf_dout), .count(buf_cnt), .full(buf_full), .empty(buf_empty)
  );
  fetch_buffer #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pcq (
    .clk(clk), .rst_n(rst_n), .push(hs && !redirect), .pop(live), .flush(redirect),
    .din(pc_q), .dout(pcq_head), .count(pcq_cnt), .full(pcq_full), .empty(pcq_empty)
  );
  assign head = buf_empty ? '0 : buf_dout;
  assign bus.if_valid = !buf_empty;
  assign bus.if_pc = head.pc;
  assign bus.if_inst = head.inst;
  assign bus.if_adel = head.adel;
  assert property (@(posedge clk) disable iff (!rst_n) !(buf_push && buf_full && !pop && !redirect));
  assert property (@(posedge clk) disable iff (!rst_n) !(hs && !redirect && pcq_full && !live));
  assert property (@(posedge clk) disable iff (!rst_n) !(live && pcq_empty));
  assert property (@(posedge clk) disable iff (!rst_n) pcq_cnt <= out_q);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard of expected IF/ID entries and a budgeted imem model.
module tb_fetch_stage;
  import pipe_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  fetch_stage_if bus ();
  fetch_stage #(.RESET_PC(32'h0000_3000), .BUF_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0, budget = 0;
  bit hold = 0, mon_en = 1, hs_pend = 0;
  logic [31:0] hs_addr;
  logic [31:0] pendq[$];
  if_entry_t exp_q[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back(if_entry_t'{pc: p, inst: inst_of(p), adel: 1'b0});
  endtask

  function automatic bit idle();
    return exp_q.size() == 0 && pendq.size() == 0 && !hs_pend && !bus.imem_resp_valid &&
           !bus.if_valid && budget == 0;
  endfunction

  task automatic drain(input int n);
    for (int i = 0; i < n && !idle(); i++) @(negedge clk);
    chk("drain", 32'(idle()), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = t;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
  endtask

  // memory: accepts up to 'budget' requests, answers one cycle later unless held
  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_inst = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pendq.delete();
        hs_pend = 0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
      end else begin
        if (hs_pend) pendq.push_back(hs_addr);
        if (!hold && pendq.size() > 0) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_inst = inst_of(pendq.pop_front());
        end else begin
          bus.imem_resp_valid = 1'b0;
          bus.imem_resp_inst = '0;
        end
        bus.imem_req_ready = budget > 0;
        hs_pend = bus.imem_req_valid && bus.imem_req_ready;
        hs_addr = bus.imem_req_addr;
        if (hs_pend) budget--;
      end
    end
  end

  initial begin
    if_entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && bus.if_valid && !bus.id_stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_entry got pc=%h inst=%h adel=%b", bus.if_pc, bus.if_inst, bus.if_adel);
        end else begin
          e = exp_q.pop_front();
          if (bus.if_pc !== e.pc || bus.if_inst !== e.inst || bus.if_adel !== e.adel) begin
            errors++;
            $display("FAIL entry got pc=%h inst=%h adel=%b want pc=%h inst=%h adel=%b",
                     bus.if_pc, bus.if_inst, bus.if_adel, e.pc, e.inst, e.adel);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // reset fetch and streaming
    for (int i = 0; i < 4; i++) expect_pc(32'h3000 + 32'(4 * i));
    budget = 4;
    n = 0;
    while (!bus.imem_req_valid && n < 20) begin @(negedge clk); n++; end
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0000_3000);
    chk("first_if_valid", 32'(bus.if_valid), 32'd0);
    drain(100);
    // stall: credits run out, then resume in order
    bus.id_stall = 1'b1;
    for (int i = 0; i < 6; i++) expect_pc(32'h3010 + 32'(4 * i));
    budget = 6;
    repeat (4) @(negedge clk);
    chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("stall_if_pc", bus.if_pc, 32'h0000_3010);
    @(posedge clk); #1;
    bus.id_stall = 1'b0;
    drain(100);
    // two in flight, redirect to 3100
    hold = 1;
    budget = 2;
    repeat (4) @(negedge clk);
    chk("inflight_req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    expect_pc(32'h3100);
    expect_pc(32'h3104);
    budget = 2;
    redirect(32'h0000_3100);
    hold = 0;
    drain(100);
    // redirect coinciding with a handshake and a live response
    hold = 1;
    budget = 1;
    repeat (3) @(posedge clk); #1;
    hold = 0;
    budget = 1;
    expect_pc(32'h3300);
    expect_pc(32'h3304);
    redirect(32'h0000_3300);
    budget = 2;
    drain(100);
    // misaligned target: adel entry then halt until next redirect
    exp_q.push_back(if_entry_t'{pc: 32'h0000_3102, inst: 32'h0, adel: 1'b1});
    redirect(32'h0000_3102);
    budget = 4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) expect_pc(32'h3200 + 32'(4 * i));
    redirect(32'h0000_3200);
    drain(100);
    // asynchronous reset between edges
    mon_en = 0;
    bus.id_stall = 1'b1;
    budget = 4;
    repeat (6) @(negedge clk);
    chk("pre_rst_if_valid", 32'(bus.if_valid), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_if_valid", 32'(bus.if_valid), 32'd0);
    chk("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("async_if_pc", bus.if_pc, 32'd0);
    chk("async_if_inst", bus.if_inst, 32'd0);
    chk("async_if_adel", 32'(bus.if_adel), 32'd0);
    budget = 0;
    bus.id_stall = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1;
    expect_pc(32'h3000);
    budget = 1;
    drain(100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
